imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory. It accepts a byte stream over a

---
 rtl/imem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// ----------------------------------------------------------------------------
// Write-side loader for the instruction memory. It takes a byte stream over a
// valid/ready handshake and packs every 4 bytes into one 32-bit instruction
// word, most significant byte first. Each word is written through the memory
// write port at consecutive word addresses starting at base_addr. While a load
// is in progress the CPU is held (cpu_hold) so that fetch never reads a
// partially loaded program.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   After the last data word, 4 more bytes (MSB first) are taken as the
//   expected checksum. They are compared against a running 32-bit sum of all
//   written words, and err is set on mismatch. Exposes chk_sum.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins a load (ignored unless idle)
//   base_addr  in   first word address, sampled on start
//   word_cnt   in   number of words to load, sampled on start
//   in_byte    in   stream data byte
//   in_valid   in   in_byte is valid
//   in_ready   out  loader accepts in_byte this cycle
//   mem_we     out  instruction-memory write enable
//   mem_addr   out  word address of the write
//   mem_wdata  out  assembled instruction word
//   busy       out  load in progress
//   cpu_hold   out  same as busy; holds the CPU PC/fetch
//   done       out  one-cycle pulse at load completion
//   err        out  sticky error (address wrap or checksum mismatch)
//   chk_sum    out  running sum of written words (LOADER_CHECKSUM_EN only)
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk_sum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     words_left;
    logic [1:0]          byte_idx;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_next;
`ifdef LOADER_CHECKSUM_EN
    // Set once the 4th checksum byte is in; the compare happens the cycle after.
    logic                chk_pending;
`endif

    // Incoming byte shifted in at the bottom so the first byte ends up as MSB.
    assign shreg_next = {shreg[DATA_W-9:0], in_byte};

`ifdef LOADER_CHECKSUM_EN
    assign in_ready = (state == S_COLLECT) || ((state == S_CHECK) && !chk_pending);
`else
    assign in_ready = (state == S_COLLECT);
`endif

    assign cpu_hold = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_pending <= 1'b0;
            chk_sum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= base_addr;
                        words_left <= word_cnt;
                        err        <= 1'b0;
                        byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_sum     <= '0;
                        chk_pending <= 1'b0;
`endif
                        if (word_cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_COLLECT;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (in_valid) begin
                        shreg    <= shreg_next;
                        byte_idx <= byte_idx + 2'd1;
                        // Registered write outputs are loaded here so that
                        // mem_we is high exactly while the state is WRITE.
                        if (byte_idx == 2'd3) begin
                            state     <= S_WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= shreg_next;
                        end
                    end
                end

                S_WRITE: begin
                    mem_we     <= 1'b0;
                    addr       <= addr + ADDR_W'(1);
                    words_left <= words_left - (ADDR_W+1)'(1);
                    // Incrementing past all-ones wraps to 0: flag it.
                    if (addr == '1) begin
                        err <= 1'b1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    chk_sum <= chk_sum + mem_wdata;
`endif
                    if (words_left == (ADDR_W+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state       <= S_CHECK;
                        chk_pending <= 1'b0;
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        state <= S_COLLECT;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (chk_pending) begin
                        if (shreg != chk_sum) begin
                            err <= 1'b1;
                        end
                        chk_pending <= 1'b0;
                        state       <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (in_valid) begin
                        shreg    <= shreg_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            chk_pending <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader
// ----------------------------------------------------------------------------
// Directed and randomized loads against a queue-based reference: expected
// write addresses/words, error flag, done count and load latency are computed
// from the byte stream with plain arithmetic. Also exercises asynchronous
// reset in the middle of a word. Define LOADER_CHECKSUM_EN to cover the
// checksum variant.
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_cnt = '0;
    logic [7:0]        in_byte = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       chk_sum;
`endif

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
`ifdef LOADER_CHECKSUM_EN
        ,
        .chk_sum   (chk_sum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: sample outputs on the falling edge.
    logic [ADDR_W+31:0] wr_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic rdy_seen = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we)   wr_q.push_back({mem_addr, mem_wdata});
            if (done)     begin done_cnt++; done_cyc = cyc; end
            if (in_ready) rdy_seen = 1'b1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Data bytes of the next load (4 per word), filled by the caller.
    logic [7:0] tx_q[$];

    task automatic do_load(input string tag, input int base, input int cnt,
                           input int mode, input logic [31:0] chk_delta);
        logic [31:0] exp_words[$];
        int          exp_addr[$];
        logic [7:0]  stream[$];
        logic [31:0] w;
        logic [31:0] sum;
        logic        exp_err;
        logic        vld;
        logic        tog;
        logic        tmo;
        int          start_cyc;
        int          exp_lat;
        int          idx;
        int          guard;

        sum = 0;
        exp_err = 1'b0;
        stream = tx_q;
        for (int i = 0; i < cnt; i++) begin
            w = (32'(tx_q[4*i]) << 24) | (32'(tx_q[4*i+1]) << 16) |
                (32'(tx_q[4*i+2]) << 8) | 32'(tx_q[4*i+3]);
            exp_words.push_back(w);
            exp_addr.push_back((base + i) % DEPTH);
            sum += w;
            if ((base + i) % DEPTH == DEPTH - 1) exp_err = 1'b1;
        end
        exp_lat = 5 * cnt;
`ifdef LOADER_CHECKSUM_EN
        if (cnt > 0) begin
            w = sum + chk_delta;
            stream.push_back(w[31:24]);
            stream.push_back(w[23:16]);
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
            if (chk_delta != 0) exp_err = 1'b1;
            exp_lat += 5;
        end
`endif

        wr_q.delete();
        done_cnt = 0;
        rdy_seen = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        base_addr = base[ADDR_W-1:0];
        word_cnt  = cnt[ADDR_W:0];
        start_cyc = cyc + 1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 13'($urandom);
        word_cnt  = 14'($urandom);
        chk({tag, "_err_cleared"}, err, 0);
        if (cnt > 0) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_hold"}, cpu_hold, 1);
        end

        idx = 0;
        guard = 0;
        tog = 1'b1;
        while (idx < stream.size() && guard < 2000) begin
            if (mode == 0)      vld = 1'b1;
            else if (mode == 1) vld = tog;
            else                vld = 1'($urandom_range(0, 1));
            tog = !tog;
            in_valid = vld;
            in_byte  = vld ? stream[idx] : 8'($urandom);
            // Spurious start pulses mid-load must be ignored.
            if (mode == 2 && $urandom_range(0, 5) == 0) begin
                start     = 1'b1;
                base_addr = 13'($urandom);
                word_cnt  = 14'($urandom);
            end else begin
                start = 1'b0;
            end
            if (vld && in_ready) idx++;
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        tmo = (guard >= 2000);
        chk({tag, "_stream_timeout"}, tmo, 0);

        // Keep in_valid high with junk: outside the collect phase it is ignored.
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
            guard++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_write_count"}, wr_q.size(), cnt);
        for (int i = 0; i < cnt && i < wr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_q[i][ADDR_W+31:32], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), wr_q[i][31:0], exp_words[i]);
        end
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_hold_after"}, cpu_hold, 0);
        chk({tag, "_ready_after"}, in_ready, 0);
        if (mode == 0) chk({tag, "_latency"}, done_cyc - start_cyc, exp_lat);
        if (cnt == 0)  chk({tag, "_ready_never"}, rdy_seen, 0);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_chk_sum"}, chk_sum, sum);
`endif
        $display("load %s base=%h cnt=%0d mode=%0d writes=%0d err=%0b",
                 tag, base, cnt, mode, wr_q.size(), err);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two words from base 0
        tx_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        do_load("basic", 0, 2, 0, 0);

        // in_valid toggling every cycle
        tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_load("toggle", 'h055, 1, 1, 0);

        // Empty load
        tx_q.delete();
        do_load("empty", 'h100, 0, 0, 0);

        // Address wrap from all-ones to zero
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        do_load("wrap", 'h1FFF, 2, 0, 0);

        // Next start clears err (checked in do_load right after start)
        tx_q = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        do_load("after_wrap", 'h0200, 1, 2, 0);

        // Asynchronous reset after 2 bytes of a word
        @(negedge clk);
        start = 1'b1; base_addr = 13'h010; word_cnt = 14'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_byte = 8'hAA;
        @(negedge clk);
        in_byte = 8'hBB;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load("post_rst", 'h020, 1, 0, 0);

        // Randomized loads
        for (int r = 0; r < 8; r++) begin
            int cnt;
            int base;
            int mode;
            cnt  = $urandom_range(1, 4);
            base = $urandom_range(0, 8000);
            mode = $urandom_range(0, 2);
            tx_q.delete();
            for (int b = 0; b < 4 * cnt; b++) tx_q.push_back(8'($urandom));
            do_load($sformatf("rand%0d", r), base, cnt, mode, 0);
        end

`ifdef LOADER_CHECKSUM_EN
        // Good and bad checksum for words 1 and 2
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        do_load("chk_good", 'h100, 2, 0, 0);
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        do_load("chk_bad", 'h100, 2, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
